pid_ctrl_param: RTL and testbench

Parametrised, fully pipelined PID steering controller. It is the next generation of the fixed-width PID block. It converts a signed heading error and a forward speed into left and right motor speeds. New over the previous generation:
- run-time gains and term enables
- clamping (not freezing) anti-windup, with a status flag
- configurable derivative history depth
- two-sided speed saturation
- an explicit output-valid strobe

---
 rtl/pid_pkg.sv | 39 +++
 rtl/pid_ctrl_param_if.sv | 37 +++
 rtl/pid_integrator.sv | 46 ++++
 rtl/pid_ctrl_param.sv | 116 +++++++++++
 tb/tb_pid_ctrl_param.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pid_pkg.sv
// pid_pkg: shared helpers and default parameter values for the PID
// steering controller.
//   sat_s   : saturate a signed value to the signed range of a given width
//   clamp_u : clamp a signed value to [0, 2^width - 1]
//   DEF_*   : default parameter values used by the interface and modules
package pid_pkg;

  localparam int DEF_ERR_W   = 12;
  localparam int DEF_SAT_W   = 10;
  localparam int DEF_FWD_W   = 10;
  localparam int DEF_INT_W   = 15;
  localparam int DEF_I_SHIFT = 6;
  localparam int DEF_D_DEPTH = 3;
  localparam int DEF_DSAT_W  = 8;
  localparam int DEF_KP_W    = 6;
  localparam int DEF_KD_W    = 5;
  localparam int DEF_PID_W   = 14;

  function automatic logic signed [31:0] sat_s(input logic signed [31:0] value,
                                               input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

  function automatic logic [31:0] clamp_u(input logic signed [31:0] value,
                                          input int width);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< width) - 32'sd1;
    if (value < 32'sd0)  return 32'd0;
    else if (value > hi) return $unsigned(hi);
    else                 return $unsigned(value);
  endfunction

endpackage

// File: rtl/pid_ctrl_param_if.sv
// pid_ctrl_param_if: sample/config inputs and speed outputs of the PID
// steering controller.
//   master : drives moving, err_vld, error, frwrd, kp, kd, i_en, d_en, clr_int;
//            receives lft_spd, rght_spd, spd_vld, int_sat
//   slave  : the controller side (opposite directions)
interface pid_ctrl_param_if
  import pid_pkg::*;
#(
  parameter int ERR_W = DEF_ERR_W,
  parameter int FWD_W = DEF_FWD_W,
  parameter int KP_W  = DEF_KP_W,
  parameter int KD_W  = DEF_KD_W
);
  logic                    moving;
  logic                    err_vld;
  logic signed [ERR_W-1:0] error;
  logic [FWD_W-1:0]        frwrd;
  logic [KP_W-1:0]         kp;
  logic [KD_W-1:0]         kd;
  logic                    i_en;
  logic                    d_en;
  logic                    clr_int;
  logic [FWD_W:0]          lft_spd;
  logic [FWD_W:0]          rght_spd;
  logic                    spd_vld;
  logic                    int_sat;

  modport master (
    output moving, err_vld, error, frwrd, kp, kd, i_en, d_en, clr_int,
    input  lft_spd, rght_spd, spd_vld, int_sat
  );

  modport slave (
    input  moving, err_vld, error, frwrd, kp, kd, i_en, d_en, clr_int,
    output lft_spd, rght_spd, spd_vld, int_sat
  );
endinterface

// File: rtl/pid_integrator.sv
// pid_integrator: clamping integrator with clear/hold and saturation flag.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear integrator and int_sat (highest priority)
//   upd      : accumulate err_s this cycle
//   err_s    : saturated error sample
//   integ    : integrator value
//   int_sat  : last update hit the range limit; held until the next update
module pid_integrator
  import pid_pkg::*;
#(
  parameter int SAT_W = DEF_SAT_W,
  parameter int INT_W = DEF_INT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    upd,
  input  logic signed [SAT_W-1:0] err_s,
  output logic signed [INT_W-1:0] integ,
  output logic                    int_sat
);

  logic signed [31:0]      sum;
  logic signed [INT_W-1:0] sum_sat;

  always_comb begin
    sum     = 32'(integ) + 32'(err_s);
    sum_sat = INT_W'(sat_s(sum, INT_W));
  end

  // Clamping anti-windup: an overflowing sum stores the limit rather than
  // freezing the previous value, so the integrator sits at the rail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ   <= '0;
      int_sat <= 1'b0;
    end else if (clr) begin
      integ   <= '0;
      int_sat <= 1'b0;
    end else if (upd) begin
      integ   <= sum_sat;
      int_sat <= (32'(sum_sat) != sum);
    end
  end

endmodule

// File: rtl/pid_ctrl_param.sv
// pid_ctrl_param: three-stage pipelined PID steering controller.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pid_ctrl_param_if slave (error sample + config in, speeds out)
// Stage 1 saturates the error, stage 2 forms the P/I/D sum and updates the
// integrator and derivative history, stage 3 turns the sum into clamped
// left/right speeds with a one-cycle spd_vld strobe.
module pid_ctrl_param
  import pid_pkg::*;
#(
  parameter int ERR_W   = DEF_ERR_W,
  parameter int SAT_W   = DEF_SAT_W,
  parameter int FWD_W   = DEF_FWD_W,
  parameter int INT_W   = DEF_INT_W,
  parameter int I_SHIFT = DEF_I_SHIFT,
  parameter int D_DEPTH = DEF_D_DEPTH,
  parameter int DSAT_W  = DEF_DSAT_W,
  parameter int KP_W    = DEF_KP_W,
  parameter int KD_W    = DEF_KD_W,
  parameter int PID_W   = DEF_PID_W
) (
  input logic             clk,
  input logic             rst,
  pid_ctrl_param_if.slave bus
);

  localparam int SPD_W = FWD_W + 1;

  logic signed [ERR_W-1:0] error_in;
  logic [FWD_W-1:0]        frwrd_in;
  logic [KP_W-1:0]         kp_in;
  logic [KD_W-1:0]         kd_in;

  assign error_in = bus.error;
  assign frwrd_in = bus.frwrd;
  assign kp_in    = bus.kp;
  assign kd_in    = bus.kd;

  logic                    v1_reg, v2_reg, spd_vld_reg;
  logic signed [SAT_W-1:0] err_s_reg;
  logic signed [SAT_W-1:0] hist_reg [D_DEPTH];
  logic signed [PID_W-1:0] pid_reg;
  logic [SPD_W-1:0]        lft_reg, rght_reg;
  logic signed [INT_W-1:0] integ;
  logic                    int_sat;

  logic signed [SAT_W-1:0] err_sat;
  logic signed [31:0]      p_term, i_term, d_diff, d_term, adj, lft_raw, rght_raw;
  logic signed [PID_W-1:0] pid_next;
  logic [SPD_W-1:0]        lft_next, rght_next;

  // Intermediates are 32 bits wide; with these operand widths none of the
  // sums can wrap, so they match the narrower sizes the arithmetic needs.
  always_comb begin
    err_sat   = SAT_W'(sat_s(32'(error_in), SAT_W));
    p_term    = 32'(err_s_reg) * 32'(signed'({1'b0, kp_in}));
    i_term    = 32'(integ) >>> I_SHIFT;
    d_diff    = sat_s(32'(err_s_reg) - 32'(hist_reg[D_DEPTH-1]), DSAT_W);
    d_term    = bus.d_en ? d_diff * 32'(signed'({1'b0, kd_in})) : 32'sd0;
    pid_next  = PID_W'(sat_s((p_term >>> 1) + i_term + d_term, PID_W));
    adj       = 32'(pid_reg) >>> 3;
    lft_raw   = 32'(signed'({1'b0, frwrd_in})) + adj;
    rght_raw  = 32'(signed'({1'b0, frwrd_in})) - adj;
    lft_next  = SPD_W'(clamp_u(lft_raw, FWD_W));
    rght_next = SPD_W'(clamp_u(rght_raw, FWD_W));
  end

  // The I term above reads integ before this cycle's update lands.
  pid_integrator #(
    .SAT_W(SAT_W),
    .INT_W(INT_W)
  ) u_integ (
    .clk    (clk),
    .rst    (rst),
    .clr    (bus.clr_int | ~bus.moving),
    .upd    (v1_reg & bus.i_en),
    .err_s  (err_s_reg),
    .integ  (integ),
    .int_sat(int_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      spd_vld_reg <= 1'b0;
      err_s_reg   <= '0;
      pid_reg     <= '0;
      lft_reg     <= '0;
      rght_reg    <= '0;
      for (int i = 0; i < D_DEPTH; i++) hist_reg[i] <= '0;
    end else begin
      v1_reg <= bus.err_vld;
      if (bus.err_vld) err_s_reg <= err_sat;

      v2_reg <= v1_reg;
      if (v1_reg) begin
        pid_reg     <= pid_next;
        // History advances on every sample, independent of d_en and moving.
        hist_reg[0] <= err_s_reg;
        for (int i = 1; i < D_DEPTH; i++) hist_reg[i] <= hist_reg[i-1];
      end

      spd_vld_reg <= v2_reg;
      if (v2_reg) begin
        lft_reg  <= bus.moving ? lft_next  : '0;
        rght_reg <= bus.moving ? rght_next : '0;
      end
    end
  end

  assign bus.lft_spd  = lft_reg;
  assign bus.rght_spd = rght_reg;
  assign bus.spd_vld  = spd_vld_reg;
  assign bus.int_sat  = int_sat;

endmodule

// File: tb/tb_pid_ctrl_param.sv
// tb_pid_ctrl_param: randomized + directed bench for pid_ctrl_param with a
// scoreboard. The driver runs a sample-level reference model and queues the
// expected speeds; a monitor pops and compares on every spd_vld.
module tb_pid_ctrl_param;
  localparam int ERR_W = 12, SAT_W = 10, FWD_W = 10, INT_W = 15, I_SHIFT = 6;
  localparam int D_DEPTH = 3, DSAT_W = 8, KP_W = 6, KD_W = 5, PID_W = 14;
  localparam int SPD_MAX = (1 << FWD_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  pid_ctrl_param_if #(.ERR_W(ERR_W), .FWD_W(FWD_W), .KP_W(KP_W), .KD_W(KD_W)) bus ();

  pid_ctrl_param #(
    .ERR_W(ERR_W), .SAT_W(SAT_W), .FWD_W(FWD_W), .INT_W(INT_W), .I_SHIFT(I_SHIFT),
    .D_DEPTH(D_DEPTH), .DSAT_W(DSAT_W), .KP_W(KP_W), .KD_W(KD_W), .PID_W(PID_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int lft;
    int rght;
    int sat;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Configuration applied with every driven cycle.
  int s_fw = 512, s_kp = 0, s_kd = 0;
  bit s_ie = 0, s_de = 0, s_mv = 1, s_clr = 0;

  // Reference model state: sample waiting for its sum, sum waiting for speeds,
  // integrator, flag, and the last D_DEPTH saturated errors (oldest first).
  bit m1_v, m2_v;
  int m1_e, m2_pid, m_integ;
  int m_sat;
  int m_hist[$];

  function automatic int sat(int v, int w);
    int hi, lo;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic int lim(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m1_v = 0; m2_v = 0; m1_e = 0; m2_pid = 0; m_integ = 0; m_sat = 0;
    m_hist.delete();
    for (int i = 0; i < D_DEPTH; i++) m_hist.push_back(0);
    exp_q.delete();
  endtask

  // Drive one cycle, advance the model across the coming clock edge, and
  // return at the following falling edge.
  task automatic step(input bit vld, input int err);
    int  adj, p, it, dd, d, s, npid;
    bit  push;
    exp_t e;
    bus.err_vld = vld;
    bus.error   = ERR_W'(err);
    bus.frwrd   = FWD_W'(s_fw);
    bus.kp      = KP_W'(s_kp);
    bus.kd      = KD_W'(s_kd);
    bus.i_en    = s_ie;
    bus.d_en    = s_de;
    bus.moving  = s_mv;
    bus.clr_int = s_clr;

    push = 0;
    npid = 0;
    if (m2_v) begin
      adj    = m2_pid >>> 3;
      e.lft  = s_mv ? lim(s_fw + adj, 0, SPD_MAX) : 0;
      e.rght = s_mv ? lim(s_fw - adj, 0, SPD_MAX) : 0;
      e.cyc  = cyc_cnt + 1;
      push   = 1;
    end
    if (m1_v) begin
      p    = m1_e * s_kp;
      it   = m_integ >>> I_SHIFT;
      dd   = sat(m1_e - m_hist[0], DSAT_W);
      d    = s_de ? dd * s_kd : 0;
      npid = sat((p >>> 1) + it + d, PID_W);
    end
    if (s_clr || !s_mv) begin
      m_integ = 0;
      m_sat   = 0;
    end else if (m1_v && s_ie) begin
      s       = m_integ + m1_e;
      m_integ = sat(s, INT_W);
      m_sat   = (s != m_integ) ? 1 : 0;
    end
    if (m1_v) begin
      m_hist.push_back(m1_e);
      void'(m_hist.pop_front());
    end
    m2_v   = m1_v;
    m2_pid = npid;
    m1_v   = vld;
    m1_e   = sat(err, SAT_W);
    if (push) begin
      e.sat = m_sat;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Single sample with exact latency and value checks.
  task automatic shot(input string name, input int err, input int want_l, input int want_r);
    step(1, err);
    step(0, 0);
    check({name, "_early_vld"}, bus.spd_vld, 0);
    step(0, 0);
    check({name, "_vld"}, bus.spd_vld, 1);
    check({name, "_lft"}, bus.lft_spd, want_l);
    check({name, "_rght"}, bus.rght_spd, want_r);
    step(0, 0);
  endtask

  // Monitor: compare every presented speed pair against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.spd_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_spd_vld", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency_cycle", cyc_cnt, e.cyc);
          check("lft_spd", bus.lft_spd, e.lft);
          check("rght_spd", bus.rght_spd, e.rght);
          check("int_sat", bus.int_sat, e.sat);
          $display("txn cyc=%0d lft=%0d rght=%0d int_sat=%0d", cyc_cnt,
                   bus.lft_spd, bus.rght_spd, bus.int_sat);
        end
      end
    end
  end

  initial begin
    int t5_err[7] = '{0, 0, 0, 100, 100, 100, 100};
    int t5_l[7]   = '{0, 0, 0, 599, 599, 599, 512};
    int t5_r[7]   = '{0, 0, 0, 425, 425, 425, 512};
    int err;

    bus.err_vld = 0; bus.error = '0; bus.frwrd = '0; bus.kp = '0; bus.kd = '0;
    bus.i_en = 0; bus.d_en = 0; bus.moving = 1; bus.clr_int = 0;
    model_reset();
    @(negedge clk);
    check("reset_lft", bus.lft_spd, 0);
    check("reset_rght", bus.rght_spd, 0);
    check("reset_vld", bus.spd_vld, 0);
    check("reset_int_sat", bus.int_sat, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic P path, error/speed saturation, lower clamp.
    s_kp = 16; s_ie = 0; s_de = 0; s_mv = 1;
    s_fw = 512; shot("t1", 256, 768, 256);
    s_fw = 600; shot("t2", 2047, 1023, 89);
    s_fw = 100; shot("t3", -512, 0, 612);

    // Anti-windup: clamp at the rail, step off it, then clear.
    s_kp = 0; s_ie = 1; s_fw = 512;
    for (int i = 0; i < 40; i++) step(1, 511);
    step(0, 0); step(0, 0);
    check("t4_int_sat_set", bus.int_sat, 1);
    step(1, -10); step(0, 0); step(0, 0);
    check("t4_int_sat_clr", bus.int_sat, 0);
    s_clr = 1; step(0, 0); s_clr = 0;
    s_ie = 0;
    shot("t4_after_clr", 0, 512, 512);

    // D path through the history.
    s_kp = 0; s_ie = 0; s_de = 1; s_kd = 7; s_fw = 512;
    for (int k = 0; k < 9; k++) begin
      step(k < 7, (k < 7) ? t5_err[k] : 0);
      if (k >= 5) begin
        check("t5_lft", bus.lft_spd, t5_l[k-2]);
        check("t5_rght", bus.rght_spd, t5_r[k-2]);
      end
    end
    step(0, 0);

    // moving=0 while streaming.
    s_mv = 0; s_ie = 1; s_kp = 20;
    for (int i = 0; i < 10; i++) step(1, int'($urandom_range(0, 1000)) - 500);
    step(0, 0); step(0, 0);
    check("t6_stop_lft", bus.lft_spd, 0);
    check("t6_stop_rght", bus.rght_spd, 0);
    check("t6_stop_int_sat", bus.int_sat, 0);
    s_mv = 1; s_ie = 0; s_de = 0; s_kp = 16;

    // Reset with a sample in flight.
    shot("t6_pre", 256, 768, 256);
    step(1, 256);
    step(0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_lft", bus.lft_spd, 0);
    check("mid_rst_rght", bus.rght_spd, 0);
    check("mid_rst_vld", bus.spd_vld, 0);
    check("mid_rst_int_sat", bus.int_sat, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      check("post_rst_no_vld", bus.spd_vld, 0);
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if (n % 16 == 0) begin
        s_kp = $urandom_range(0, 63);
        s_kd = $urandom_range(0, 31);
        s_ie = 1'($urandom_range(0, 1));
        s_de = 1'($urandom_range(0, 1));
        s_fw = $urandom_range(0, SPD_MAX);
      end
      s_mv  = ($urandom_range(0, 9) != 0);
      s_clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) err = int'($urandom_range(0, 4095)) - 2048;
      else                           err = int'($urandom_range(0, 1200)) - 600;
      step($urandom_range(0, 9) < 7, err);
    end
    s_clr = 0;
    for (int i = 0; i < 5; i++) step(0, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
